// File: rtl/ram_nr1w_repl.sv
// Multi-read, single-write synchronous RAM. Each read port owns a banked replica,
// and the replicas clear themselves after reset before accepting any access.
module ram_nr1w_repl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 11,
  parameter int BANK_ADDR_W = 10,
  parameter int NUM_RD      = 2,
  parameter bit BYPASS      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_din,
  input  logic                     w_enb,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  input  logic [NUM_RD-1:0]        r_enb,
  output logic [NUM_RD*DATA_W-1:0] r_dout,
  output logic [NUM_RD-1:0]        r_valid,
  output logic                     init_busy
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBANK  = 1 << (ADDR_W - BANK_ADDR_W);
  localparam int BDEPTH = 1 << BANK_ADDR_W;
  localparam int SEL_W  = (ADDR_W > BANK_ADDR_W) ? (ADDR_W - BANK_ADDR_W) : 1;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              init_busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_q     <= ST_READY;
        init_busy_q <= 1'b0;
      end
    end
  end

  assign init_busy = init_busy_q;

  // Shared write path: the clear sequence owns the write port while in INIT.
  logic              ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [NUM_RD-1:0] rd_acc;

  assign ready    = (state_q == ST_READY) && !rst;
  assign mem_we   = !rst && ((state_q == ST_INIT) || w_enb);
  assign mem_addr = (state_q == ST_INIT) ? cnt_q : w_addr;
  assign mem_din  = (state_q == ST_INIT) ? '0 : w_din;
  assign rd_acc   = r_enb & {NUM_RD{ready}};

  logic [SEL_W-1:0]       mem_bank;
  logic [BANK_ADDR_W-1:0] mem_off;

  assign mem_off = mem_addr[BANK_ADDR_W-1:0];

  if (NBANK > 1) begin : g_wsel
    assign mem_bank = mem_addr[ADDR_W-1:BANK_ADDR_W];
  end else begin : g_wnosel
    assign mem_bank = '0;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0]      ra;
    logic [SEL_W-1:0]       rd_bank;
    logic [BANK_ADDR_W-1:0] rd_off;
    logic [DATA_W-1:0]      bank_rd [NBANK];
    logic [SEL_W-1:0]       sel_q;
    logic                   hit_q;
    logic [DATA_W-1:0]      byp_q;
    logic                   vld_q;
    logic                   zero_q;
    logic [DATA_W-1:0]      dout;

    assign ra     = r_addr[k*ADDR_W +: ADDR_W];
    assign rd_off = ra[BANK_ADDR_W-1:0];

    if (NBANK > 1) begin : g_rsel
      assign rd_bank = ra[ADDR_W-1:BANK_ADDR_W];
    end else begin : g_rnosel
      assign rd_bank = '0;
    end

    // zero_q forces r_dout to 0 from reset until this port's first accepted read,
    // so the bank read registers themselves need no reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        zero_q <= 1'b1;
      end else begin
        vld_q <= rd_acc[k];
        if (rd_acc[k]) zero_q <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rd_acc[k]) begin
        sel_q <= rd_bank;
        hit_q <= BYPASS && w_enb && (w_addr == ra);
        byp_q <= w_din;
      end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
      logic [DATA_W-1:0] mem [BDEPTH];
      logic [DATA_W-1:0] rd_q;

      // Read-first block RAM: a same-cycle write is seen by the next read only.
      always_ff @(posedge clk) begin
        if (mem_we && (mem_bank == SEL_W'(b))) mem[mem_off] <= mem_din;
        if (rd_acc[k] && (rd_bank == SEL_W'(b))) rd_q <= mem[rd_off];
      end

      assign bank_rd[b] = rd_q;
    end

    if (NBANK > 1) begin : g_mux
      always_comb begin
        dout = bank_rd[sel_q];
        if (hit_q) dout = byp_q;
        if (zero_q) dout = '0;
      end
    end else begin : g_nomux
      always_comb begin
        dout = bank_rd[0];
        if (hit_q) dout = byp_q;
        if (zero_q) dout = '0;
      end
    end

    assign r_dout[k*DATA_W +: DATA_W] = dout;
    assign r_valid[k]                 = vld_q;
  end
endmodule

// File: tb/tb_ram_nr1w_repl.sv
// Bench for ram_nr1w_repl: a BYPASS=1 and a BYPASS=0 instance share one stimulus
// stream and are both compared against a cycle model through a scoreboard queue.
module tb_ram_nr1w_repl;
  logic        clk;
  logic        rst;
  logic [3:0]  w_addr;
  logic [31:0] w_din;
  logic        w_enb;
  logic [7:0]  r_addr;
  logic [1:0]  r_enb;
  logic [63:0] dout1, dout0;
  logic [1:0]  valid1, valid0;
  logic        busy1, busy0;

  ram_nr1w_repl #(.DATA_W(32), .ADDR_W(4), .BANK_ADDR_W(3), .NUM_RD(2), .BYPASS(1'b1)) dut_b1 (
    .clk(clk), .rst(rst), .w_addr(w_addr), .w_din(w_din), .w_enb(w_enb),
    .r_addr(r_addr), .r_enb(r_enb), .r_dout(dout1), .r_valid(valid1), .init_busy(busy1)
  );

  ram_nr1w_repl #(.DATA_W(32), .ADDR_W(4), .BANK_ADDR_W(3), .NUM_RD(2), .BYPASS(1'b0)) dut_b0 (
    .clk(clk), .rst(rst), .w_addr(w_addr), .w_din(w_din), .w_enb(w_enb),
    .r_addr(r_addr), .r_enb(r_enb), .r_dout(dout0), .r_valid(valid0), .init_busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic [1:0]  valid;
    logic [63:0] d1;
    logic [63:0] d0;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [1:0]  ev;
    logic [63:0] ed1;
    logic [63:0] ed0;
  } vec_t;

  exp_t sbq[$];
  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [16];
  logic [31:0] m_d1 [2];
  logic [31:0] m_d0 [2];
  logic [1:0]  m_vld;
  bit          m_init;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst_v, input logic we_v, input logic [3:0] wa_v,
                      input logic [31:0] wd_v, input logic [1:0] re_v,
                      input logic [3:0] ra0_v, input logic [3:0] ra1_v);
    exp_t e;
    exp_t g;
    logic [3:0] ra [2];
    rst    = rst_v;
    w_enb  = we_v;
    w_addr = wa_v;
    w_din  = wd_v;
    r_enb  = re_v;
    r_addr = {ra1_v, ra0_v};
    ra[0]  = ra0_v;
    ra[1]  = ra1_v;
    if (rst_v) begin
      m_init = 1'b1;
      m_cnt  = 0;
      m_vld  = 2'b00;
      for (int k = 0; k < 2; k++) begin
        m_d1[k] = '0;
        m_d0[k] = '0;
      end
    end else if (m_init) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 15) m_init = 1'b0;
      m_cnt++;
      m_vld = 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (re_v[k]) begin
          m_vld[k] = 1'b1;
          m_d0[k]  = m_mem[ra[k]];
          m_d1[k]  = (we_v && wa_v == ra[k]) ? wd_v : m_mem[ra[k]];
        end else begin
          m_vld[k] = 1'b0;
        end
      end
      if (we_v) m_mem[wa_v] = wd_v;
    end
    e.busy  = m_init;
    e.valid = m_vld;
    e.d1    = {m_d1[1], m_d1[0]};
    e.d0    = {m_d0[1], m_d0[0]};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    check("busy_b1",  {63'd0, busy1},  {63'd0, g.busy});
    check("busy_b0",  {63'd0, busy0},  {63'd0, g.busy});
    check("valid_b1", {62'd0, valid1}, {62'd0, g.valid});
    check("valid_b0", {62'd0, valid0}, {62'd0, g.valid});
    check("dout_b1",  dout1, g.d1);
    check("dout_b0",  dout0, g.d0);
  endtask

  // Runs the clear with accesses attempted every cycle and counts busy cycles.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    if (busy1) n++;
    for (int i = 0; i < 40 && busy1; i++) begin
      step(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 2'b11, 4'd5, 4'd5);
      if (busy1) n++;
    end
    check(name, 64'(n), 64'd16);
  endtask

  task automatic read_all(output logic [63:0] acc);
    acc = '0;
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b0, 4'd0, 32'd0, 2'b11, 4'(a), 4'(15 - a));
      acc = acc | dout1 | dout0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [10];
    logic [63:0] acc;
    int          run;
    logic [31:0] exp_w;

    tbl[0] = '{1'b1, 4'd3,  32'hA5A5_0001, 2'b00, 4'd0, 4'd0,  2'b00, 64'h0, 64'h0};
    tbl[1] = '{1'b1, 4'd11, 32'h5A5A_0002, 2'b00, 4'd0, 4'd0,  2'b00, 64'h0, 64'h0};
    tbl[2] = '{1'b0, 4'd0,  32'h0,         2'b11, 4'd3, 4'd11, 2'b11,
               64'h5A5A_0002_A5A5_0001, 64'h5A5A_0002_A5A5_0001};
    tbl[3] = '{1'b1, 4'd7,  32'h1111_1111, 2'b00, 4'd0, 4'd0,  2'b00,
               64'h5A5A_0002_A5A5_0001, 64'h5A5A_0002_A5A5_0001};
    tbl[4] = '{1'b1, 4'd7,  32'h2222_2222, 2'b01, 4'd7, 4'd0,  2'b01,
               64'h5A5A_0002_2222_2222, 64'h5A5A_0002_1111_1111};
    tbl[5] = '{1'b0, 4'd0,  32'h0,         2'b01, 4'd7, 4'd0,  2'b01,
               64'h5A5A_0002_2222_2222, 64'h5A5A_0002_2222_2222};
    tbl[6] = '{1'b0, 4'd0,  32'h0,         2'b10, 4'd0, 4'd3,  2'b10,
               64'hA5A5_0001_2222_2222, 64'hA5A5_0001_2222_2222};
    tbl[7] = '{1'b1, 4'd9,  32'h3333_3333, 2'b00, 4'd0, 4'd0,  2'b00,
               64'hA5A5_0001_2222_2222, 64'hA5A5_0001_2222_2222};
    tbl[8] = '{1'b0, 4'd0,  32'h0,         2'b11, 4'd9, 4'd9,  2'b11,
               64'h3333_3333_3333_3333, 64'h3333_3333_3333_3333};
    tbl[9] = '{1'b1, 4'd12, 32'h4444_4444, 2'b11, 4'd3, 4'd12, 2'b11,
               64'h4444_4444_A5A5_0001, 64'h0000_0000_A5A5_0001};

    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_init = 1'b1;
    m_cnt  = 0;
    m_vld  = 2'b00;
    rst = 1'b1; w_enb = 1'b0; w_addr = '0; w_din = '0; r_enb = '0; r_addr = '0;

    // Reset held for 3 cycles with accesses attempted, then the clear runs.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 2'b11, 4'd5, 4'd5);
    count_busy("busy_len_init");
    read_all(acc);
    check("cleared_init", acc, 64'h0);

    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra0, tbl[i].ra1);
      check("tbl_valid_b1", {62'd0, valid1}, {62'd0, tbl[i].ev});
      check("tbl_valid_b0", {62'd0, valid0}, {62'd0, tbl[i].ev});
      check("tbl_dout_b1", dout1, tbl[i].ed1);
      check("tbl_dout_b0", dout0, tbl[i].ed0);
    end

    // Fill, then stream port 0 while port 1 holds its last result.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 4'(i), 32'hC0DE_0000 + 32'(i) + 32'd1, 2'b00, 4'd0, 4'd0);
    run = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'd0, 32'd0, 2'b01, 4'(i), 4'd0);
      exp_w = 32'hC0DE_0000 + 32'(i) + 32'd1;
      if (valid1 == 2'b01 && valid0 == 2'b01 && dout1[31:0] == exp_w && dout0[31:0] == exp_w) run++;
    end
    check("stream_run", 64'(run), 64'd16);
    check("hold_p1_b1", {32'd0, dout1[63:32]}, 64'h4444_4444);
    check("hold_p1_b0", {32'd0, dout0[63:32]}, 64'h0);

    // Reset in the middle of read traffic.
    step(1'b0, 1'b0, 4'd0, 32'd0, 2'b11, 4'd2, 4'd3);
    step(1'b1, 1'b0, 4'd0, 32'd0, 2'b11, 4'd4, 4'd5);
    check("mid_rst_valid", {62'd0, valid1 | valid0}, 64'd0);
    count_busy("busy_len_mid");
    read_all(acc);
    check("cleared_mid", acc, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_nr1w_repl.md
Name: ram_nr1w_repl

Overview:
- Parametrised multi-read, single-write synchronous RAM. Provides NUM_RD independent read ports.
- Each read port owns a full replica of the memory. Every write goes to all replicas; each replica is split into 2^(ADDR_W-BANK_ADDR_W) block-RAM banks.
- Adds three features the single-read-port generation does not have:
  - self-clearing initialisation after reset
  - per-port read enable with a valid flag
  - configurable read-during-write bypass
- Sits between the scheduling logic and the shared tables that several consumers read in the same cycle.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 11, total address width; DEPTH = 2^ADDR_W words.
- BANK_ADDR_W, 10, address width of one bank; bank count = 2^(ADDR_W-BANK_ADDR_W); must satisfy 1 <= BANK_ADDR_W <= ADDR_W.
- NUM_RD, 2, number of read ports (replicas), >= 1.
- BYPASS, 1, 1 = write-first on same-cycle same-address collision; 0 = read-first (old data).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- w_addr  in  ADDR_W  write address.
- w_din  in  DATA_W  write data.
- w_enb  in  1  write enable.
- r_addr  in  NUM_RD*ADDR_W  packed read addresses; port k is at [k*ADDR_W +: ADDR_W].
- r_enb  in  NUM_RD  per-port read enable.
- r_dout  out  NUM_RD*DATA_W  packed read data; port k is at [k*DATA_W +: DATA_W].
- r_valid  out  NUM_RD  per-port flag: r_dout slice is valid this cycle.
- init_busy  out  1  high while the clear sequence runs; no accesses are accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to INIT and the clear counter goes to 0.
  - r_dout = 0, r_valid = 0, init_busy = 1.
  - Memory contents are not reset directly; the INIT state clears them.
- FSM states are INIT and READY.
- INIT state:
  - Each cycle writes 0 to address cnt in every replica, then cnt increments.
  - When cnt = DEPTH-1 is written, the next state is READY.
  - init_busy stays 1 for exactly DEPTH cycles after rst falls. The first accepted access is on cycle DEPTH, counting the first cycle with rst=0 as cycle 0.
- Accesses during INIT:
  - w_enb and r_enb are ignored.
  - r_valid stays 0 and r_dout stays 0.
- Reset in the middle of INIT or READY: returns to INIT with cnt = 0 and restarts the full clear.
- Write (READY, w_enb=1):
  - Bank select = w_addr[ADDR_W-1:BANK_ADDR_W]; only that bank in each replica gets its write enable.
  - In-bank address = w_addr[BANK_ADDR_W-1:0].
  - When BANK_ADDR_W = ADDR_W there is a single bank and no select logic.
- Read (READY, r_enb[k]=1):
  - Latency is 1 cycle: r_dout[k] and r_valid[k]=1 appear on the edge after the request.
  - The bank select is registered with the request and drives the output mux in the data cycle.
  - Ports are fully independent; any set of ports may read the same or different addresses in the same cycle.
- Read disabled (r_enb[k]=0): r_valid[k]=0 next cycle; r_dout[k] holds its last value.
- Collision (w_enb=1, r_enb[k]=1, r_addr[k]=w_addr in the same cycle):
  - BYPASS=1: r_dout[k] returns w_din.
  - BYPASS=0: r_dout[k] returns the pre-write contents.
  - The stored value is always updated.
- Write followed by read of the same address on the next cycle returns the new data, independent of BYPASS.
- Back-to-back reads on a port sustain one result per cycle.
- All read results are identical across replicas for identical addresses: replicas never diverge.

Test Plan:
Bench parameters for all scenarios: DATA_W=32, ADDR_W=4, BANK_ADDR_W=3, NUM_RD=2.
- Reset and clear, BYPASS=1: hold rst for 3 cycles, then release.
  - init_busy is 1 for exactly 16 cycles.
  - r_valid=0 throughout, even with r_enb=2'b11 asserted.
  - After the clear, reads of addresses 0..15 on both ports return 0.
- Bank steering, BYPASS=1:
  - Write 0xA5A5_0001 to address 3 (bank 0) and 0x5A5A_0002 to address 11 (bank 1).
  - Read address 3 on port 0 and address 11 on port 1 in one cycle.
  - Next cycle: r_dout = {0x5A5A_0002, 0xA5A5_0001} and r_valid = 2'b11.
- Collision, BYPASS=1 then BYPASS=0:
  - Preload address 7 with 0x1111_1111.
  - In one cycle, write 0x2222_2222 to address 7 and read address 7 on port 0.
  - Port 0 returns 0x2222_2222 with BYPASS=1 and 0x1111_1111 with BYPASS=0.
  - The next read of address 7 returns 0x2222_2222 in both cases.
- Independent ports and hold:
  - Port 0 streams addresses 0..15, one per cycle, while port 1 has r_enb=0.
  - Port 0 r_valid stays high for 16 consecutive cycles with the correct data.
  - Port 1 r_valid=0 and its r_dout is unchanged.
- Reset mid-traffic:
  - Fill the memory with nonzero data, then assert rst for 1 cycle during reads.
  - r_valid drops to 0 at that edge and init_busy is high for 16 cycles.
  - All subsequent reads return 0.
- Writes ignored during INIT:
  - Drive w_enb=1 with address 5 and data 0xDEAD_BEEF during the clear.
  - After READY, address 5 reads 0.
